// File: rtl/led_walker_pkg.sv
// Shared types and helpers for the LED walker.
package led_walker_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WALK = 1'b1
   } walk_state_t;

   typedef enum logic {
      MODE_BOUNCE = 1'b0,
      MODE_WRAP   = 1'b1
   } walk_mode_t;

   // Number of divider strobes that make up one complete pass.
   function automatic int unsigned steps_per_pass(walk_mode_t mode, int unsigned n);
      return (mode == MODE_WRAP) ? n : (2 * n - 2);
   endfunction

endpackage

// File: rtl/req_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
module req_sync_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_pulse;

   // Synchronise the raw input and emit one pulse per rising edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_meta  <= i_async;
         r_sync  <= r_meta;
         r_prev  <= r_sync;
         r_pulse <= r_sync & ~r_prev;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/led_walker.sv
// Request-triggered LED walker: bounce or wrap patterns over N LEDs.
module led_walker
   import led_walker_pkg::*;
#(
   parameter int unsigned NUM_LEDS      = 4,
   parameter int unsigned COUNTER_WIDTH = 25,
   parameter int unsigned CYCLES_WIDTH  = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_req,
   input  logic                    i_mode,
   input  logic [CYCLES_WIDTH-1:0] i_cycles,
   input  logic                    i_abort,
   output logic [NUM_LEDS-1:0]     o_led,
   output logic                    o_busy,
   output logic                    o_done
);

   localparam int unsigned POS_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int unsigned STEP_W = $clog2(2 * NUM_LEDS);

   logic                     w_start;
   logic                     w_stb;
   logic                     w_last_step;
   logic                     w_last_pass;

   walk_state_t              r_state,    w_state_nxt;
   walk_mode_t               r_mode,     w_mode_nxt;
   logic [CYCLES_WIDTH-1:0]  r_passes,   w_passes_nxt;
   logic [CYCLES_WIDTH-1:0]  r_pass_cnt, w_pass_cnt_nxt;
   logic [POS_W-1:0]         r_pos,      w_pos_nxt;
   logic                     r_dir,      w_dir_nxt;
   logic [STEP_W-1:0]        r_step,     w_step_nxt;
   logic [COUNTER_WIDTH-1:0] r_div,      w_div_nxt;
   logic                     r_pending,  w_pending_nxt;
   logic [NUM_LEDS-1:0]      r_led,      w_led_nxt;
   logic                     r_busy,     w_busy_nxt;
   logic                     r_done,     w_done_nxt;

   req_sync_edge u_req_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_async (i_req),
      .o_pulse (w_start)
   );

   assign w_stb       = &r_div;
   assign w_last_step = (r_step == STEP_W'(steps_per_pass(r_mode, NUM_LEDS) - 32'd1));
   assign w_last_pass = (r_pass_cnt == r_passes - CYCLES_WIDTH'(1));

   // State and datapath registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_mode     <= MODE_BOUNCE;
         r_passes   <= CYCLES_WIDTH'(1);
         r_pass_cnt <= '0;
         r_pos      <= '0;
         r_dir      <= 1'b0;
         r_step     <= '0;
         r_div      <= '0;
         r_pending  <= 1'b0;
         r_led      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_mode     <= w_mode_nxt;
         r_passes   <= w_passes_nxt;
         r_pass_cnt <= w_pass_cnt_nxt;
         r_pos      <= w_pos_nxt;
         r_dir      <= w_dir_nxt;
         r_step     <= w_step_nxt;
         r_div      <= w_div_nxt;
         r_pending  <= w_pending_nxt;
         r_led      <= w_led_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   // Next-state, step sequencing and registered output values.
   always_comb begin
      w_state_nxt    = r_state;
      w_mode_nxt     = r_mode;
      w_passes_nxt   = r_passes;
      w_pass_cnt_nxt = r_pass_cnt;
      w_pos_nxt      = r_pos;
      w_dir_nxt      = r_dir;
      w_step_nxt     = r_step;
      w_div_nxt      = r_div + COUNTER_WIDTH'(1);
      w_pending_nxt  = r_pending;
      w_done_nxt     = 1'b0;

      case (r_state)
         IDLE: begin
            // A pending request restarts after exactly one idle cycle.
            if (r_pending || (w_start && !i_abort)) begin
               w_state_nxt    = WALK;
               w_mode_nxt     = walk_mode_t'(i_mode);
               w_passes_nxt   = (i_cycles == '0) ? CYCLES_WIDTH'(1) : i_cycles;
               w_pass_cnt_nxt = '0;
               w_pos_nxt      = '0;
               w_dir_nxt      = 1'b0;
               w_step_nxt     = '0;
               w_div_nxt      = '0;
               w_pending_nxt  = 1'b0;
            end
         end
         WALK: begin
            if (i_abort) begin
               w_state_nxt   = IDLE;
               w_pending_nxt = 1'b0;
            end else begin
               if (w_start) begin
                  w_pending_nxt = 1'b1;
               end
               if (w_stb) begin
                  if (w_last_step) begin
                     if (w_last_pass) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                     end else begin
                        w_pass_cnt_nxt = r_pass_cnt + CYCLES_WIDTH'(1);
                     end
                     w_step_nxt = '0;
                     w_pos_nxt  = '0;
                     w_dir_nxt  = 1'b0;
                  end else begin
                     w_step_nxt = r_step + STEP_W'(1);
                     if (r_mode == MODE_WRAP || !r_dir) begin
                        if (r_mode == MODE_BOUNCE && r_pos == POS_W'(NUM_LEDS - 1)) begin
                           w_dir_nxt = 1'b1;
                           w_pos_nxt = r_pos - POS_W'(1);
                        end else begin
                           w_pos_nxt = r_pos + POS_W'(1);
                        end
                     end else begin
                        w_pos_nxt = r_pos - POS_W'(1);
                     end
                  end
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == WALK);
      w_led_nxt  = (w_state_nxt == WALK) ? (NUM_LEDS'(1) << w_pos_nxt) : '0;
   end

   assign o_led  = r_led;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: tb/tb_led_walker.sv
// Directed bench for led_walker with 2, 4 and 8 LED instances.
module tb_led_walker;

   logic       clk = 1'b0;
   logic       rst;
   logic       req4, req2, req8;
   logic       mode;
   logic       abort;
   logic [3:0] cycles;
   logic [3:0] led4;
   logic [1:0] led2;
   logic [7:0] led8;
   logic       busy4, busy2, busy8;
   logic       done4, done2, done8;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] cap_led  [0:63];
   logic       cap_busy [0:63];
   logic       cap_done [0:63];

   always #5 clk = ~clk;

   led_walker #(.NUM_LEDS(4), .COUNTER_WIDTH(2), .CYCLES_WIDTH(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_req(req4), .i_mode(mode), .i_cycles(cycles),
      .i_abort(abort), .o_led(led4), .o_busy(busy4), .o_done(done4));

   led_walker #(.NUM_LEDS(2), .COUNTER_WIDTH(2), .CYCLES_WIDTH(4)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_req(req2), .i_mode(1'b0), .i_cycles(cycles),
      .i_abort(abort), .o_led(led2), .o_busy(busy2), .o_done(done2));

   led_walker #(.NUM_LEDS(8), .COUNTER_WIDTH(2), .CYCLES_WIDTH(4)) dut8 (
      .i_clk(clk), .i_rst(rst), .i_req(req8), .i_mode(1'b1), .i_cycles(cycles),
      .i_abort(abort), .o_led(led8), .o_busy(busy8), .o_done(done8));

   // Sample one instance's outputs on n consecutive falling edges.
   task automatic capture(input int sel, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         case (sel)
            2: begin cap_led[i] = {6'b0, led2}; cap_busy[i] = busy2; cap_done[i] = done2; end
            8: begin cap_led[i] = led8;         cap_busy[i] = busy8; cap_done[i] = done8; end
            default: begin cap_led[i] = {4'b0, led4}; cap_busy[i] = busy4; cap_done[i] = done4; end
         endcase
      end
   endtask

   // One-cycle request pulse; returns on the falling edge just before the first LED.
   task automatic start_req(input int sel);
      @(negedge clk);
      case (sel)
         2: req2 = 1'b1;
         8: req8 = 1'b1;
         default: req4 = 1'b1;
      endcase
      @(negedge clk);
      req2 = 1'b0; req4 = 1'b0; req8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; req4 = 1'b0; req2 = 1'b0; req8 = 1'b0;
      mode = 1'b0; abort = 1'b0; cycles = 4'd1;
      repeat (3) @(negedge clk);
      n_total++;
      if ({led4, busy4, done4} !== 6'b0) $display("FAIL reset4: got %b expected 000000", {led4, busy4, done4});
      else n_pass++;
      n_total++;
      if ({led2, busy2, done2} !== 4'b0) $display("FAIL reset2: got %b expected 0000", {led2, busy2, done2});
      else n_pass++;
      n_total++;
      if ({led8, busy8, done8} !== 10'b0) $display("FAIL reset8: got %b expected 0", {led8, busy8, done8});
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_bounce;
      int bseq [0:5];
      bseq = '{1, 2, 4, 8, 4, 2};
      mode = 1'b0; cycles = 4'd1;
      start_req(4);
      n_total++;
      if ({led4, busy4} !== 5'b0) $display("FAIL bounce_latency: got %b expected 00000 before edge k+3", {led4, busy4});
      else n_pass++;
      capture(4, 26);
      for (int i = 0; i < 24; i++) begin
         n_total++;
         if ({cap_led[i], cap_busy[i], cap_done[i]} !== {8'(bseq[i/4]), 1'b1, 1'b0})
            $display("FAIL bounce_cyc%0d: led=%h busy=%b done=%b expected led=%h busy=1 done=0",
                     i, cap_led[i], cap_busy[i], cap_done[i], 8'(bseq[i/4]));
         else n_pass++;
      end
      n_total++;
      if ({cap_led[24], cap_busy[24], cap_done[24]} !== {8'h00, 1'b0, 1'b1})
         $display("FAIL bounce_end: led=%h busy=%b done=%b expected 00/0/1", cap_led[24], cap_busy[24], cap_done[24]);
      else n_pass++;
      n_total++;
      if (cap_done[25] !== 1'b0) $display("FAIL bounce_done_width: done=%b expected 0", cap_done[25]);
      else n_pass++;
   endtask

   task automatic test_wrap;
      mode = 1'b1; cycles = 4'd2;
      start_req(4);
      capture(4, 34);
      for (int i = 0; i < 32; i++) begin
         n_total++;
         if ({cap_led[i], cap_busy[i]} !== {8'd1 << ((i / 4) % 4), 1'b1})
            $display("FAIL wrap2_cyc%0d: led=%h busy=%b expected led=%h busy=1",
                     i, cap_led[i], cap_busy[i], 8'd1 << ((i / 4) % 4));
         else n_pass++;
      end
      n_total++;
      if ({cap_led[32], cap_busy[32], cap_done[32], cap_done[33]} !== {8'h00, 1'b0, 1'b1, 1'b0})
         $display("FAIL wrap2_end: led=%h busy=%b done=%b,%b expected 00/0/1,0",
                  cap_led[32], cap_busy[32], cap_done[32], cap_done[33]);
      else n_pass++;

      cycles = 4'd0;
      start_req(4);
      capture(4, 18);
      for (int i = 0; i < 16; i++) begin
         n_total++;
         if (cap_led[i] !== (8'd1 << (i / 4)))
            $display("FAIL wrap0_cyc%0d: led=%h expected %h", i, cap_led[i], 8'd1 << (i / 4));
         else n_pass++;
      end
      n_total++;
      if ({cap_led[16], cap_busy[16], cap_done[16], cap_busy[17]} !== {8'h00, 1'b0, 1'b1, 1'b0})
         $display("FAIL wrap0_end: led=%h busy=%b done=%b busy_next=%b expected 00/0/1/0",
                  cap_led[16], cap_busy[16], cap_done[16], cap_busy[17]);
      else n_pass++;
   endtask

   task automatic test_pending;
      int bseq [0:5];
      bseq = '{1, 2, 4, 8, 4, 2};
      mode = 1'b0; cycles = 4'd1;
      start_req(4);
      fork
         capture(4, 46);
         begin
            repeat (3) @(negedge clk);
            req4 = 1'b1;
            @(negedge clk);
            req4 = 1'b0;
            repeat (3) @(negedge clk);
            req4 = 1'b1;
            @(negedge clk);
            req4 = 1'b0;
            mode = 1'b1;
         end
      join
      for (int i = 0; i < 24; i++) begin
         n_total++;
         if ({cap_led[i], cap_busy[i]} !== {8'(bseq[i/4]), 1'b1})
            $display("FAIL pend_first_cyc%0d: led=%h busy=%b expected led=%h busy=1",
                     i, cap_led[i], cap_busy[i], 8'(bseq[i/4]));
         else n_pass++;
      end
      n_total++;
      if ({cap_led[24], cap_busy[24], cap_done[24]} !== {8'h00, 1'b0, 1'b1})
         $display("FAIL pend_gap: led=%h busy=%b done=%b expected 00/0/1", cap_led[24], cap_busy[24], cap_done[24]);
      else n_pass++;
      for (int i = 25; i < 41; i++) begin
         n_total++;
         if ({cap_led[i], cap_busy[i]} !== {8'd1 << ((i - 25) / 4), 1'b1})
            $display("FAIL pend_second_cyc%0d: led=%h busy=%b expected led=%h busy=1",
                     i, cap_led[i], cap_busy[i], 8'd1 << ((i - 25) / 4));
         else n_pass++;
      end
      n_total++;
      if ({cap_led[41], cap_busy[41], cap_done[41]} !== {8'h00, 1'b0, 1'b1})
         $display("FAIL pend_second_end: led=%h busy=%b done=%b expected 00/0/1", cap_led[41], cap_busy[41], cap_done[41]);
      else n_pass++;
      n_total++;
      if ({cap_busy[42], cap_busy[43], cap_busy[44], cap_busy[45]} !== 4'b0)
         $display("FAIL pend_no_third: busy=%b%b%b%b expected 0000",
                  cap_busy[42], cap_busy[43], cap_busy[44], cap_busy[45]);
      else n_pass++;
      mode = 1'b0;
   endtask

   task automatic test_abort;
      int  bseq [0:5];
      logic bad;
      bseq = '{1, 2, 4, 8, 4, 2};
      mode = 1'b0; cycles = 4'd1;
      start_req(4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_total++;
         if (led4 !== 4'(bseq[i/4])) $display("FAIL abort_pre_cyc%0d: led=%h expected %h", i, led4, 4'(bseq[i/4]));
         else n_pass++;
         if (i == 2) req4 = 1'b1;
         if (i == 3) req4 = 1'b0;
         if (i == 9) abort = 1'b1;
      end
      @(negedge clk);
      abort = 1'b0;
      n_total++;
      if ({led4, busy4, done4} !== 6'b0) $display("FAIL abort_stop: got %b expected 000000", {led4, busy4, done4});
      else n_pass++;
      bad = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (busy4 || done4) bad = 1'b1;
      end
      n_total++;
      if (bad !== 1'b0) $display("FAIL abort_no_restart: saw busy/done=1 expected none");
      else n_pass++;
   endtask

   task automatic test_async_reset;
      mode = 1'b0; cycles = 4'd1;
      start_req(4);
      repeat (6) @(negedge clk);
      n_total++;
      if (busy4 !== 1'b1) $display("FAIL areset_pre_busy: busy=%b expected 1", busy4);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_total++;
      if ({led4, busy4, done4} !== 6'b0) $display("FAIL areset_immediate: got %b expected 000000", {led4, busy4, done4});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_req(4);
      @(negedge clk);
      n_total++;
      if ({led4, busy4} !== 5'b00011) $display("FAIL areset_fresh: led=%h busy=%b expected led=1 busy=1", led4, busy4);
      else n_pass++;
      repeat (30) @(negedge clk);
   endtask

   task automatic test_sizes;
      cycles = 4'd1;
      start_req(2);
      capture(2, 10);
      for (int i = 0; i < 8; i++) begin
         n_total++;
         if ({cap_led[i], cap_busy[i]} !== {8'd1 << (i / 4), 1'b1})
            $display("FAIL n2_cyc%0d: led=%h busy=%b expected led=%h busy=1", i, cap_led[i], cap_busy[i], 8'd1 << (i / 4));
         else n_pass++;
      end
      n_total++;
      if ({cap_led[8], cap_busy[8], cap_done[8]} !== {8'h00, 1'b0, 1'b1})
         $display("FAIL n2_end: led=%h busy=%b done=%b expected 00/0/1", cap_led[8], cap_busy[8], cap_done[8]);
      else n_pass++;

      start_req(8);
      capture(8, 34);
      for (int i = 0; i < 32; i++) begin
         n_total++;
         if ({cap_led[i], cap_busy[i]} !== {8'd1 << (i / 4), 1'b1})
            $display("FAIL n8_cyc%0d: led=%h busy=%b expected led=%h busy=1", i, cap_led[i], cap_busy[i], 8'd1 << (i / 4));
         else n_pass++;
      end
      n_total++;
      if ({cap_led[32], cap_busy[32], cap_done[32]} !== {8'h00, 1'b0, 1'b1})
         $display("FAIL n8_end: led=%h busy=%b done=%b expected 00/0/1", cap_led[32], cap_busy[32], cap_done[32]);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_wrap();
      test_pending();
      test_abort();
      test_async_reset();
      test_sizes();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/led_walker.md
# led_walker

Parametrised LED walker triggered by a request input. Generalises the fixed 4-LED, single-pass bounce walker to N LEDs, with bounce or wrap patterns, a programmable pass count, a one-deep pending-request latch, abort, and busy/done status. It sits between a raw push-button input and the board LED bank. Status outputs let a higher-level sequencer chain walks.

## Interface

Parameters:
- NUM_LEDS, 4: LED count; must be at least 2.
- COUNTER_WIDTH, 25: step divider width; each step lasts 2^COUNTER_WIDTH cycles.
- CYCLES_WIDTH, 4: width of the pass-count input.

Ports:
- i_clk  in  1  system clock; the block uses one clock only.
- i_rst  in  1  reset; asynchronous, active-high.
- i_req  in  1  raw asynchronous request (button); a rising edge starts a walk.
- i_mode  in  1  0 = bounce, 1 = wrap; sampled at walk start.
- i_cycles  in  CYCLES_WIDTH  number of passes; 0 is treated as 1; sampled at walk start.
- i_abort  in  1  synchronous level; terminates the walk immediately.
- o_led  out  NUM_LEDS  one-hot LED drive, or all zero when idle; registered.
- o_busy  out  1  high while in WALK; registered.
- o_done  out  1  one-cycle pulse when a walk completes normally; registered.

## Operation

Request path:
- i_req passes through a 2-flop synchroniser and then a rising-edge detector.
- The edge detector produces the registered one-cycle pulse `start`.

State machine, IDLE ↔ WALK:
- **IDLE:** o_led = 0, o_busy = 0. On `start`:
  - latch mode and passes (`passes = max(i_cycles, 1)`);
  - set pos = 0, dir = up, pass_cnt = 0;
  - clear the divider counter;
  - go to WALK.
- **WALK:** o_led = one-hot(pos). On each divider carry (stb), advance one step:
  - **Wrap:** pos goes 0 → N-1 and then back to 0. One pass is NUM_LEDS steps.
  - **Bounce:** pos goes 0 → N-1, then N-2 → 1, and then back to 0. One pass is 2·NUM_LEDS-2 steps.
  - When the step that would close pass `passes` occurs, go to IDLE, set o_led = 0, and pulse o_done.
- **Pending request:** a `start` during WALK sets `pending`; further starts while pending are ignored.
  - On normal completion with pending set, pass through IDLE for exactly one cycle.
  - Then start a new walk, re-sampling i_mode and i_cycles, and clear pending.
- **Abort:** i_abort high in WALK forces IDLE on the next edge.
  - o_led = 0 and pending is cleared.
  - No o_done pulse.
  - Abort has priority over stb and start in the same cycle.
  - Abort in IDLE has no effect, but a `start` in that same cycle is dropped.
- **Simultaneous events:** a `start` in the same cycle as the final stb sets pending, so the walk restarts as described above.
- **Reset:** asynchronous, including mid-walk. Outputs go to 0 at once. State = IDLE; pending, counters and synchroniser flops are all cleared.

## Timing

- i_req first sampled high at edge k. Then:
  - `start` is high after edge k+2;
  - o_busy = 1 and o_led = 1 after edge k+3.
- Each LED position is held for exactly 2^COUNTER_WIDTH cycles, because the divider is cleared at start.
- o_done, o_busy falling, and o_led going to 0 all change on the same edge.
- Walk duration = passes × steps-per-pass × 2^COUNTER_WIDTH cycles.
- Pending restart: o_busy is low for exactly 1 cycle between walks.
- Divider: free-running in IDLE; its value there is irrelevant.

## Structure

- Shared package `led_walker_pkg` contains:
  - `walk_state_t` (IDLE, WALK);
  - `walk_mode_t` (MODE_BOUNCE = 0, MODE_WRAP = 1);
  - a function `steps_per_pass(mode, n)`.
- One sub-module, `req_sync_edge`: 2-flop synchroniser plus rising-edge pulse. It is reset by i_rst and is reusable for other buttons.
- pos width is $clog2(NUM_LEDS); pass counter width is CYCLES_WIDTH.

## Test plan

All scenarios use NUM_LEDS=4 and COUNTER_WIDTH=2 unless stated.

1. Bounce, i_cycles=1, single i_req pulse:
   - o_led reads 1,2,4,8,4,2, each held 4 cycles, then 0.
   - o_busy is high for 24 cycles; o_done pulses once.
   - First LED appears 3 edges after i_req is sampled.
2. Wrap, i_cycles=2: o_led reads 1,2,4,8,1,2,4,8, 4 cycles each, then 0 with o_done. i_cycles=0 yields exactly one pass (1,2,4,8).
3. Pending requests:
   - Two i_req pulses during a walk give exactly one restart, with o_busy low for 1 cycle.
   - i_mode changed to wrap mid-walk affects only the second walk.
4. Abort at the third step (o_led=4):
   - o_led=0 and o_busy=0 next cycle, with no o_done.
   - A pending request is discarded, so there is no restart.
5. i_rst asserted asynchronously mid-walk:
   - Outputs are 0 before the next clock edge.
   - After release, a fresh i_req walks from o_led=1.
6. NUM_LEDS=2 bounce: o_led reads 1,2, then 0. With NUM_LEDS=8 wrap, o_led shows 8 distinct one-hot values in order.
